// File: rtl/barret_acc_3517_if.sv
// rtl/barret_acc_3517_if.sv - residue in-stream and frame-result out-stream of the mod-Q frame accumulator
interface barret_acc_3517_if #(
    parameter int CNT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [11:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [11:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             range_err;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, range_err
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, range_err
    );
endinterface

// File: rtl/barret_acc_3517.sv
// rtl/barret_acc_3517.sv - per-frame modular accumulator of Barrett-reduced residues with a one-deep result register
module barret_acc_3517 #(
    parameter int Q     = 3517,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    barret_acc_3517_if.slave      bus
);
    localparam logic [11:0]      Q12     = 12'(Q);
    localparam logic [12:0]      Q13     = 13'(Q);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [11:0]      acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic [11:0]      out_data_q;
    logic [CNT_W-1:0] out_count_q;
    logic             range_err_q;

    logic             in_ready_c;
    logic             accept;
    logic             beat_err;
    logic [11:0]      d;
    logic [12:0]      sum;
    logic [11:0]      acc_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             err_next;

    // Datapath: one conditional subtract per step keeps acc in [0, Q-1]
    always_comb begin
        beat_err = bus.in_data >= Q12;
        d        = beat_err ? bus.in_data - Q12 : bus.in_data;
        sum      = {1'b0, acc_q} + {1'b0, d};
        acc_next = (sum >= Q13) ? 12'(sum - Q13) : sum[11:0];
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        err_next = err_q | beat_err;
    end

    // Control: HOLD still accepts beats when the result drains on the same edge
    always_comb begin
        state_d    = state_q;
        in_ready_c = (state_q == ST_ACC) || bus.out_ready;
        accept     = bus.in_valid && in_ready_c;
        if (accept && bus.in_last) begin
            state_d = ST_HOLD;
        end else if (state_q == ST_HOLD && bus.out_ready) begin
            state_d = ST_ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            range_err_q <= 1'b0;
        end else if (accept) begin
            if (bus.in_last) begin
                out_data_q  <= acc_next;
                out_count_q <= cnt_inc;
                range_err_q <= err_next;
                acc_q       <= '0;
                cnt_q       <= '0;
                err_q       <= 1'b0;
            end else begin
                acc_q <= acc_next;
                cnt_q <= cnt_inc;
                err_q <= err_next;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.range_err = range_err_q;
endmodule

// File: doc/barret_acc_3517.md
BARRET_ACC_3517 -- requirements
Module: barret_acc_3517

Interface
REQ-001 Parameter: Q, 3517, modulus; residues are in [0, Q-1].
REQ-002 Parameter: CNT_W, 16, width of the per-frame beat counter.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: in_valid  input  1  upstream Barrett-reduced residue present.
REQ-007 Port: in_ready  output  1  block accepts a beat this cycle.
REQ-008 Port: in_data  input  12  residue from the Barrett reducer (dout_r).
REQ-009 Port: in_last  input  1  beat closes the current frame.
REQ-010 Port: out_valid  output  1  frame result held.
REQ-011 Port: out_ready  input  1  downstream takes the result.
REQ-012 Port: out_data  output  12  frame sum mod Q.
REQ-013 Port: out_count  output  CNT_W  beats in the frame, including the last beat.
REQ-014 Port: range_err  output  1  at least one frame input was >= Q.

Function
REQ-015 A beat SHALL be accepted on a rising edge where in_valid && in_ready && !rst.
REQ-016 in_ready SHALL be the combinational function !out_valid || out_ready.
REQ-017 Each accepted input SHALL be normalised: d = in_data - Q if in_data >= Q, else in_data.
  - For 12-bit in_data, d is always < Q.
REQ-018 Accumulation: s = acc + d as a 13-bit sum; acc_next = s - Q if s >= Q, else s; acc SHALL always be < Q.
REQ-019 On an accepted non-last beat: acc <= acc_next; cnt <= cnt+1, saturating at 2^CNT_W-1; err <= err | (in_data >= Q).
REQ-020 On an accepted last beat, the output registers SHALL load as follows:
  - out_data <= acc_next;
  - out_count <= saturated cnt+1;
  - range_err <= err | (in_data >= Q);
  - out_valid <= 1.
  - In the same edge: acc <= 0, cnt <= 0, err <= 0.
REQ-021 Latency: out_valid SHALL rise on the first edge after the clock cycle in which the last beat is accepted.
REQ-022 While out_valid=1 && out_ready=0, the block SHALL hold out_data, out_count and range_err stable, and accept no beats.
REQ-023 On an output handshake (out_valid && out_ready) with no last beat accepted, out_valid SHALL clear on that edge.
REQ-024 If the output handshake and an accepted last beat occur on the same edge, the output registers SHALL load the new frame and out_valid SHALL stay 1 (zero-bubble back-to-back frames).
REQ-025 If the output handshake and an accepted non-last beat occur on the same edge, the beat SHALL accumulate into the fresh frame.
REQ-026 Sustained throughput SHALL be one beat per cycle while out_ready=1.
REQ-027 Control states are derived from out_valid:
  - ACC (out_valid=0): accepting beats.
  - HOLD (out_valid=1): result pending.
  - Transitions are exactly as in REQ-020 and REQ-022 to REQ-024.

Reset
REQ-028 While rst=1 at an edge, the block SHALL set to 0: acc, cnt, err, out_valid, out_data, out_count, range_err.
REQ-029 Beats presented during rst SHALL be discarded.
REQ-030 Reset mid-frame SHALL drop the partial frame; no output is produced for it.
REQ-031 After reset, in_ready SHALL be 1.

Verification
REQ-032 Reset, then beats 3000, 1000(last) -> out_data=483, out_count=2, range_err=0.
REQ-033 Single beat 3516(last) -> out_data=3516, out_count=1.
REQ-034 Frame {5(last)} with out_ready=0 for 5 cycles while in_valid=1 with beat 7:
  - out_data=5 stays stable; in_ready=0; beat 7 is not accepted until the handshake.
REQ-035 Frame A {1, 2(last)} and frame B {3516, 3516(last)}, with out_ready=1 and B's last beat on A's handshake edge:
  - results 3 then 3515; out_valid stays high with no gap.
REQ-036 Beat 4095(last) -> out_data=578, range_err=1; the next frame {10(last)} -> out_data=10, range_err=0.
REQ-037 Beats 100, 200, then rst for 1 cycle, then 5(last) -> exactly one result: out_data=5, out_count=1.
